buzzer_scheduler: RTL
=====================

# buzzer_scheduler

Arbitrates the single buzzer between the three ring sources of the clock: alarm match, timer end and stopwatch overflow. It latches one-cycle request pulses, grants the highest-priority source, and drives an on/off beep pattern for a bounded ring session. It handles stop and snooze clicks and runs the alarm snooze countdown. It sits between the state machine / counters and `BuzerManager`; `out_beep` feeds that block's `in_button`.

## Interface
- `beep_cycles`, 25000000: clock cycles per half-period of the ring pattern (on, then off); ≥2.
- `ring_sec`, 30: ring session length in `sec_tick` pulses before auto-stop; ≥1.
- `snooze_sec`, 300: snooze delay in `sec_tick` pulses before the alarm re-rings; ≥1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `_rst`  in  1  asynchronous, active-low reset.
- `sec_tick`  in  1  one-cycle pulse once per second.
- `req_alarm`  in  1  one-cycle alarm-match pulse.
- `req_timer`  in  1  one-cycle timer-reached-zero pulse.
- `req_stopwatch`  in  1  one-cycle stopwatch-overflow pulse.
- `in_stop`  in  1  one-cycle click (ok/cancel) ending the session.
- `in_snooze`  in  1  one-cycle click (up/down) requesting snooze.
- `out_beep`  out  1  buzzer enable pattern.
- `out_src`  out  2  granted source: 00 none, 01 alarm, 10 timer, 11 stopwatch.
- `out_snoozing`  out  1  snooze countdown is active.
- `out_busy`  out  1  ring session in progress.

## Operation
- Source priority: alarm (1) > timer (2) > stopwatch (3).
- `pend[3:1]` holds one pending bit per source. A source's `req_*` pulse sets its bit. Granting a source clears its bit.
- The snooze timer reaching 0 sets `pend[1]` internally.
- Requests are never counted. Repeated pulses while a bit is already set collapse into one.
- State machine states: IDLE and RING.
- **IDLE:**
  - `out_beep`=0, `out_src`=0.
  - If any `pend` bit or any `req_*` is high this cycle, grant the highest-priority source and go to RING.
  - On grant: `ring_cnt`←`ring_sec`, `phase_cnt`←0, `phase`←1.
- **RING:**
  - `out_beep`=`phase`.
  - `phase_cnt` counts 0..`beep_cycles`-1. At the last value it wraps to 0 and `phase` toggles.
  - Each `sec_tick` decrements `ring_cnt`. A `sec_tick` while `ring_cnt`==1 ends the session: go to IDLE, which is a timeout.
  - `in_stop` ends the session and goes to IDLE.
  - `in_snooze` with `out_src`==01: go to IDLE, `snooze_cnt`←`snooze_sec`, `out_snoozing`←1.
  - `in_snooze` for any other source acts as `in_stop`.
  - Preemption: a strictly higher-priority request (pulse or pending) restarts RING for that source, with counters reloaded as on grant. The preempted source is dropped, not re-queued. Equal or lower priority requests stay pending.
- **Snooze timer** (independent of state):
  - While `out_snoozing`=1, each `sec_tick` decrements `snooze_cnt`.
  - A tick while `snooze_cnt`==1: `out_snoozing`←0 and `pend[1]`←1.
  - An external `req_alarm` while snoozing clears `out_snoozing`; that alarm rings normally.
  - `in_stop` while in IDLE with `out_snoozing`=1 cancels the snooze.
- **Simultaneous events:**
  - `in_stop` beats `in_snooze`.
  - Stop/timeout and a new request in the same cycle: the session ends, the request is latched in `pend`, and it is granted on the next cycle.
  - `sec_tick` on the grant/reload cycle is ignored; the reload wins.
- Counter widths: `$clog2(ring_sec+1)`, `$clog2(snooze_sec+1)`, `$clog2(beep_cycles)`. No arithmetic wraps below 0.

## Timing
- Reset (`_rst`=0, asynchronous): state IDLE, `pend`=0, all counters 0.
- Output reset values: `out_beep`=0, `out_src`=00, `out_snoozing`=0, `out_busy`=0.
- All outputs are registered.
- Grant latency: a request pulse sampled at edge N from IDLE gives `out_busy`=1, `out_src` valid and `out_beep`=1 after edge N.
- Pattern timing: `out_beep` is high for `beep_cycles` cycles, then low for `beep_cycles` cycles, repeating. The phase restarts high on every grant or preemption.
- Stop/snooze/timeout: outputs return to idle values after the same edge that samples the event.
- A re-ring from an internally set `pend[1]` starts one cycle after the expiry tick.
- Reset mid-session or mid-snooze aborts everything immediately, with no residual pending bits.

## Test plan
Bench parameters: `beep_cycles`=4, `ring_sec`=3, `snooze_sec`=5, `sec_tick` every 20 cycles.

1. **Reset and basic ring:** reset, then pulse `req_timer`.
   - Next cycle: `out_src`=10, `out_busy`=1.
   - `out_beep` pattern 1111 0000 repeating.
   - After the 3rd `sec_tick`: IDLE, all outputs 0.
2. **Stop:** ring a stopwatch request, then pulse `in_stop` after 7 cycles.
   - `out_beep`=0 and `out_src`=00 on the next cycle.
   - Pulse `in_snooze` on a timer ring: same result, and `out_snoozing` stays 0.
3. **Snooze:** ring an alarm, then pulse `in_snooze`.
   - `out_snoozing`=1.
   - After 5 ticks: `out_snoozing`=0 and `out_src`=01 one cycle later.
   - Repeat, but pulse `in_stop` during the snooze: no re-ring.
4. **Preemption and queuing:** start a stopwatch ring, pulse `req_alarm`.
   - `out_src`→01 and the pattern restarts high.
   - Pulse `req_timer` during the alarm ring, then `in_stop`: the timer rings on the next cycle.
   - The stopwatch never resumes.
5. **Simultaneous events:**
   - `req_alarm`, `req_timer` and `req_stopwatch` in one cycle from IDLE: grant 01, with timer and stopwatch left pending.
   - `in_stop` plus `in_snooze` on an alarm ring: stop, no snooze.
6. **Async reset mid-session:** pulse `_rst` low mid-cycle during a ring with pending bits and an active snooze.
   - Outputs go to 0 without waiting for a clock edge.
   - No ring occurs after release.

Source files
------------

// File: rtl/buzzer_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : buzzer_scheduler                                                |
// | Purpose  : Arbitrates the single buzzer between alarm, timer and stopwatch |
// |            ring sources. Latches request pulses, grants the highest       |
// |            priority source, drives an on/off beep pattern for a bounded   |
// |            ring session, and runs the alarm snooze countdown.             |
// | Ports    : clk           system clock (rising edge)                        |
// |            _rst          asynchronous active-low reset                     |
// |            sec_tick      one-cycle pulse per second                        |
// |            req_alarm     alarm-match pulse          (priority 1)           |
// |            req_timer     timer-reached-zero pulse   (priority 2)           |
// |            req_stopwatch stopwatch-overflow pulse   (priority 3)           |
// |            in_stop       click ending the session                          |
// |            in_snooze     click requesting snooze                           |
// |            out_beep      buzzer enable pattern                             |
// |            out_src       granted source (0 none,1 alarm,2 timer,3 sw)      |
// |            out_snoozing  snooze countdown active                           |
// |            out_busy      ring session in progress                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module buzzer_scheduler #(
  parameter int beep_cycles = 25000000,
  parameter int ring_sec    = 30,
  parameter int snooze_sec  = 300
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       sec_tick,
  input  logic       req_alarm,
  input  logic       req_timer,
  input  logic       req_stopwatch,
  input  logic       in_stop,
  input  logic       in_snooze,
  output logic       out_beep,
  output logic [1:0] out_src,
  output logic       out_snoozing,
  output logic       out_busy
);

  localparam int c_ring_w = $clog2(ring_sec + 1);
  localparam int c_snz_w  = $clog2(snooze_sec + 1);
  localparam int c_ph_w   = $clog2(beep_cycles);

  localparam logic [c_ring_w-1:0] c_ring_load = c_ring_w'(ring_sec);
  localparam logic [c_ring_w-1:0] c_ring_one  = c_ring_w'(1);
  localparam logic [c_ring_w-1:0] c_ring_zero = '0;
  localparam logic [c_snz_w-1:0]  c_snz_load  = c_snz_w'(snooze_sec);
  localparam logic [c_snz_w-1:0]  c_snz_one   = c_snz_w'(1);
  localparam logic [c_snz_w-1:0]  c_snz_zero  = '0;
  localparam logic [c_ph_w-1:0]   c_ph_last   = c_ph_w'(beep_cycles - 1);
  localparam logic [c_ph_w-1:0]   c_ph_one    = c_ph_w'(1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_ring = 1'b1;

  localparam logic [1:0] c_src_none  = 2'd0;
  localparam logic [1:0] c_src_alarm = 2'd1;
  localparam logic [1:0] c_src_timer = 2'd2;
  localparam logic [1:0] c_src_sw    = 2'd3;

  logic [0:0]          r_state,      w_state_nxt;
  logic [3:1]          r_pend,       w_pend_nxt;
  logic [1:0]          r_src,        w_src_nxt;
  logic [c_ring_w-1:0] r_ring_cnt,   w_ring_cnt_nxt;
  logic [c_ph_w-1:0]   r_phase_cnt,  w_phase_cnt_nxt;
  logic                r_phase,      w_phase_nxt;
  logic [c_snz_w-1:0]  r_snooze_cnt, w_snooze_cnt_nxt;
  logic                r_snoozing,   w_snoozing_nxt;
  logic                r_beep,       w_beep_nxt;
  logic                r_busy,       w_busy_nxt;

  logic [3:1] w_req;
  logic [1:0] w_grant_src;
  logic [3:1] w_grant_mask;
  logic       w_ringing;
  logic       w_timeout;
  logic       w_end;
  logic       w_snz_start;
  logic       w_do_grant;

  // Pending bits merged with this cycle's pulses: a request is visible for
  // arbitration in the same cycle it arrives.
  assign w_req = r_pend | {req_stopwatch, req_timer, req_alarm};

  always_comb begin
    w_grant_src  = c_src_none;
    w_grant_mask = 3'b000;
    if (w_req[1]) begin
      w_grant_src  = c_src_alarm;
      w_grant_mask = 3'b001;
    end else if (w_req[2]) begin
      w_grant_src  = c_src_timer;
      w_grant_mask = 3'b010;
    end else if (w_req[3]) begin
      w_grant_src  = c_src_sw;
      w_grant_mask = 3'b100;
    end
  end

  assign w_ringing   = (r_state == c_st_ring);
  assign w_timeout   = sec_tick && (r_ring_cnt == c_ring_one);
  // Any snooze click ends the session; only on an alarm does it also snooze.
  assign w_end       = w_ringing && (in_stop || in_snooze || w_timeout);
  assign w_snz_start = w_ringing && in_snooze && !in_stop && (r_src == c_src_alarm);

  // State register
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state      <= c_st_idle;
      r_pend       <= 3'b000;
      r_src        <= c_src_none;
      r_ring_cnt   <= c_ring_zero;
      r_phase_cnt  <= '0;
      r_phase      <= 1'b0;
      r_snooze_cnt <= c_snz_zero;
      r_snoozing   <= 1'b0;
      r_beep       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend       <= w_pend_nxt;
      r_src        <= w_src_nxt;
      r_ring_cnt   <= w_ring_cnt_nxt;
      r_phase_cnt  <= w_phase_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_snoozing   <= w_snoozing_nxt;
      r_beep       <= w_beep_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_src_nxt        = r_src;
    w_pend_nxt       = w_req;
    w_ring_cnt_nxt   = r_ring_cnt;
    w_phase_cnt_nxt  = r_phase_cnt;
    w_phase_nxt      = r_phase;
    w_snooze_cnt_nxt = r_snooze_cnt;
    w_snoozing_nxt   = r_snoozing;
    w_do_grant       = 1'b0;

    case (r_state)
      c_st_idle: begin
        if (w_grant_src != c_src_none) begin
          w_do_grant = 1'b1;
        end
      end
      c_st_ring: begin
        if (w_end) begin
          // Requests arriving now stay latched and win arbitration next cycle.
          w_state_nxt     = c_st_idle;
          w_src_nxt       = c_src_none;
          w_phase_cnt_nxt = '0;
          w_phase_nxt     = 1'b0;
        end else if ((w_grant_src != c_src_none) && (w_grant_src < r_src)) begin
          // Preemption: the current source is dropped, not re-queued.
          w_do_grant = 1'b1;
        end else begin
          if (r_phase_cnt == c_ph_last) begin
            w_phase_cnt_nxt = '0;
            w_phase_nxt     = !r_phase;
          end else begin
            w_phase_cnt_nxt = r_phase_cnt + c_ph_one;
          end
          if (sec_tick && (r_ring_cnt != c_ring_zero)) begin
            w_ring_cnt_nxt = r_ring_cnt - c_ring_one;
          end
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_src_nxt   = c_src_none;
      end
    endcase

    // Reload on grant; a coincident sec_tick is swallowed by the reload.
    if (w_do_grant) begin
      w_state_nxt     = c_st_ring;
      w_src_nxt       = w_grant_src;
      w_pend_nxt      = w_req & ~w_grant_mask;
      w_ring_cnt_nxt  = c_ring_load;
      w_phase_cnt_nxt = '0;
      w_phase_nxt     = 1'b1;
    end

    // Snooze countdown runs regardless of the ring state.
    if (w_snz_start) begin
      w_snoozing_nxt   = 1'b1;
      w_snooze_cnt_nxt = c_snz_load;
    end else if (r_snoozing) begin
      if (req_alarm || (in_stop && !w_ringing)) begin
        w_snoozing_nxt   = 1'b0;
        w_snooze_cnt_nxt = c_snz_zero;
      end else if (sec_tick) begin
        if (r_snooze_cnt == c_snz_one) begin
          w_snoozing_nxt   = 1'b0;
          w_snooze_cnt_nxt = c_snz_zero;
          w_pend_nxt[1]    = 1'b1;
        end else if (r_snooze_cnt != c_snz_zero) begin
          w_snooze_cnt_nxt = r_snooze_cnt - c_snz_one;
        end
      end
    end
  end

  // Output logic: registered next values derived from the next state.
  always_comb begin
    w_busy_nxt = (w_state_nxt == c_st_ring);
    w_beep_nxt = w_busy_nxt && w_phase_nxt;
  end

  assign out_beep     = r_beep;
  assign out_src      = r_src;
  assign out_snoozing = r_snoozing;
  assign out_busy     = r_busy;

endmodule
`default_nettype wire
